// File: rtl/clkdiv_scale_sequencer.sv
// Glitch-free scale sequencer for clock_divider: applies a new ratio on a divided-clock
// falling edge, then holds the divider in reset. Manual (valid/ready) or automatic sweep.
module clkdiv_scale_sequencer #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_cfg_scale,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready_c,
    input  logic             i_sweep_en,
    input  logic [WIDTH-1:0] i_sweep_lo,
    input  logic [WIDTH-1:0] i_sweep_hi,
    input  logic [WIDTH-1:0] i_dwell,
    input  logic             i_div_clk_out,
    output logic [WIDTH-1:0] o_div_scale,
    output logic             o_div_nrst,
    output logic             o_busy,
    output logic             o_timeout_err
);

    localparam int unsigned HOLD_W = $clog2(RST_CYCLES + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned CW     = WIDTH + 1;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_WAIT_EDGE,
        ST_HOLD
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_div_scale;
    logic [WIDTH-1:0]  r_pend_scale;
    logic [WIDTH-1:0]  r_edge_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_div_nrst;
    logic              r_busy;
    logic              r_timeout_err;
    logic              r_clk_q;

    state_t            w_state_nxt;
    logic [WIDTH-1:0]  w_scale_nxt;
    logic [WIDTH-1:0]  w_pend_nxt;
    logic [WIDTH-1:0]  w_edge_nxt;
    logic [TO_W-1:0]   w_to_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              w_nrst_nxt;
    logic              w_terr_nxt;

    logic              w_fall;
    logic              w_rise;
    logic [WIDTH-1:0]  w_dwell_eff;
    logic [WIDTH-1:0]  w_sweep_next;
    logic              w_step_done;
    logic              w_hold_done;

    assign w_fall      = r_clk_q & ~i_div_clk_out;
    assign w_rise      = ~r_clk_q & i_div_clk_out;
    assign w_dwell_eff = (i_dwell == '0) ? WIDTH'(1) : i_dwell;
    assign w_step_done = (CW'(r_edge_cnt) + CW'(1)) >= CW'(w_dwell_eff);
    assign w_hold_done = (r_hold_cnt == HOLD_W'(RST_CYCLES - 1));

    // Wrap to sweep_lo when outside the range or at the top; +1 cannot overflow here.
    assign w_sweep_next = ((i_sweep_lo > i_sweep_hi) || (r_div_scale < i_sweep_lo) ||
                           (r_div_scale >= i_sweep_hi)) ? i_sweep_lo
                                                        : r_div_scale + WIDTH'(1);

    assign o_cfg_ready_c = (r_state == ST_RUN) & ~i_sweep_en;
    assign o_div_scale   = r_div_scale;
    assign o_div_nrst    = r_div_nrst;
    assign o_busy        = r_busy;
    assign o_timeout_err = r_timeout_err;

    // Next-state and next-register logic
    always_comb begin
        w_state_nxt = r_state;
        w_scale_nxt = r_div_scale;
        w_pend_nxt  = r_pend_scale;
        w_edge_nxt  = r_edge_cnt;
        w_to_nxt    = r_to_cnt;
        w_hold_nxt  = r_hold_cnt;
        w_nrst_nxt  = r_div_nrst;
        w_terr_nxt  = r_timeout_err;

        case (r_state)
            ST_INIT: begin
                if (w_hold_done) begin
                    w_state_nxt = ST_RUN;
                    w_nrst_nxt  = 1'b1;
                    w_hold_nxt  = '0;
                    w_edge_nxt  = '0;
                end else begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                if (!i_sweep_en) begin
                    w_edge_nxt = '0;
                    if (i_cfg_valid && (i_cfg_scale != r_div_scale)) begin
                        w_pend_nxt  = i_cfg_scale;
                        w_to_nxt    = '0;
                        w_state_nxt = ST_WAIT_EDGE;
                    end
                end else if (w_rise) begin
                    if (!w_step_done) begin
                        w_edge_nxt = r_edge_cnt + WIDTH'(1);
                    end else if (w_sweep_next == r_div_scale) begin
                        w_edge_nxt = '0;
                    end else begin
                        w_pend_nxt  = w_sweep_next;
                        w_to_nxt    = '0;
                        w_state_nxt = ST_WAIT_EDGE;
                    end
                end
            end
            ST_WAIT_EDGE: begin
                // A real edge beats a simultaneous timeout and leaves the error flag alone.
                if (w_fall || (r_to_cnt == TO_W'(TIMEOUT - 1))) begin
                    w_state_nxt = ST_HOLD;
                    w_scale_nxt = r_pend_scale;
                    w_nrst_nxt  = 1'b0;
                    w_hold_nxt  = '0;
                    if (!w_fall) begin
                        w_terr_nxt = 1'b1;
                    end
                end else begin
                    w_to_nxt = r_to_cnt + TO_W'(1);
                end
            end
            ST_HOLD: begin
                if (w_hold_done) begin
                    w_state_nxt = ST_RUN;
                    w_nrst_nxt  = 1'b1;
                    w_hold_nxt  = '0;
                    w_edge_nxt  = '0;
                end else begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= ST_INIT;
            r_div_scale   <= WIDTH'(1);
            r_pend_scale  <= '0;
            r_edge_cnt    <= '0;
            r_to_cnt      <= '0;
            r_hold_cnt    <= '0;
            r_div_nrst    <= 1'b0;
            r_busy        <= 1'b1;
            r_timeout_err <= 1'b0;
            r_clk_q       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_div_scale   <= w_scale_nxt;
            r_pend_scale  <= w_pend_nxt;
            r_edge_cnt    <= w_edge_nxt;
            r_to_cnt      <= w_to_nxt;
            r_hold_cnt    <= w_hold_nxt;
            r_div_nrst    <= w_nrst_nxt;
            r_busy        <= (w_state_nxt != ST_RUN);
            r_timeout_err <= w_terr_nxt;
            r_clk_q       <= i_div_clk_out;
        end
    end

endmodule

// File: tb/tb_clkdiv_scale_sequencer.sv
// Bench for clkdiv_scale_sequencer: scenario tasks with inline checks plus a scoreboard
// of expected applied scales, popped whenever the divider reset is asserted by an update.
module tb_clkdiv_scale_sequencer;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] cfg_scale = '0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic             sweep_en = 1'b0;
    logic [WIDTH-1:0] sweep_lo = '0;
    logic [WIDTH-1:0] sweep_hi = '0;
    logic [WIDTH-1:0] dwell = '0;
    logic             div_clk = 1'b0;
    logic [WIDTH-1:0] div_scale;
    logic             div_nrst;
    logic             busy;
    logic             timeout_err;

    int               n_checks = 0;
    int               n_fail = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic             prev_nrst;
    bit               div_stuck = 1'b0;
    int               div_cnt = 0;

    clkdiv_scale_sequencer #(.WIDTH(WIDTH), .RST_CYCLES(2), .TIMEOUT(255)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cfg_scale  (cfg_scale),
        .i_cfg_valid  (cfg_valid),
        .o_cfg_ready_c(cfg_ready),
        .i_sweep_en   (sweep_en),
        .i_sweep_lo   (sweep_lo),
        .i_sweep_hi   (sweep_hi),
        .i_dwell      (dwell),
        .i_div_clk_out(div_clk),
        .o_div_scale  (div_scale),
        .o_div_nrst   (div_nrst),
        .o_busy       (busy),
        .o_timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Divided-clock stand-in: toggles every 4 clk cycles, or sticks at 1.
    always @(posedge clk) begin
        #2;
        if (div_stuck) begin
            div_clk = 1'b1;
        end else begin
            div_cnt++;
            if (div_cnt == 4) begin
                div_cnt = 0;
                div_clk = ~div_clk;
            end
        end
    end

    // Scoreboard: each divider reset caused by an update must carry the next expected scale.
    always @(posedge clk) begin
        logic             rst_e;
        logic [WIDTH-1:0] exp_v;
        rst_e = rst_n;
        #3;
        if (rst_e && prev_nrst === 1'b1 && div_nrst === 1'b0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_update: div_scale=%0d applied, no update expected", div_scale);
            end else begin
                exp_v = exp_q.pop_front();
                if (div_scale !== exp_v) begin
                    n_fail++;
                    $display("FAIL sb_applied_scale: got %0d, expected %0d", div_scale, exp_v);
                end
            end
        end
        prev_nrst = div_nrst;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        repeat (n) tick();
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic send_req(input logic [WIDTH-1:0] s);
        cfg_scale = s;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_nrst_low(input int budget, output int cyc);
        cyc = 0;
        while (cyc < budget && div_nrst !== 1'b0) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (div_scale !== 8'd1 || div_nrst !== 1'b0 || cfg_ready !== 1'b0 ||
                timeout_err !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_values: scale=%0d nrst=%b ready=%b terr=%b busy=%b, want 1 0 0 0 1",
                         div_scale, div_nrst, cfg_ready, timeout_err, busy);
            end
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (div_nrst !== 1'b0 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL init_hold_1: nrst=%b ready=%b, want 0 0", div_nrst, cfg_ready);
        end
        tick();
        n_checks++;
        if (div_nrst !== 1'b1 || cfg_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL init_release: nrst=%b ready=%b busy=%b, want 1 1 0", div_nrst, cfg_ready, busy);
        end
    endtask

    task automatic test_manual_change();
        logic prev_d;
        bit   seen;
        exp_q.push_back(8'd5);
        send_req(8'd5);
        n_checks++;
        if (busy !== 1'b1 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL manual_accept: busy=%b ready=%b, want 1 0", busy, cfg_ready);
        end
        prev_d = div_clk;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            n_checks++;
            if (prev_d === 1'b1 && div_clk === 1'b0) begin
                seen = 1'b1;
                if (div_nrst !== 1'b0 || div_scale !== 8'd5) begin
                    n_fail++;
                    $display("FAIL manual_apply_on_fall: nrst=%b scale=%0d, want 0 5", div_nrst, div_scale);
                end
            end else if (div_nrst !== 1'b1 || div_scale !== 8'd1) begin
                n_fail++;
                $display("FAIL manual_wait_edge: nrst=%b scale=%0d, want 1 1", div_nrst, div_scale);
            end
            prev_d = div_clk;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL manual_no_fall: no divided-clock fall seen within 40 cycles");
        end
        tick();
        n_checks++;
        if (div_nrst !== 1'b0 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL manual_hold_2: nrst=%b ready=%b, want 0 0", div_nrst, cfg_ready);
        end
        tick();
        n_checks++;
        if (div_nrst !== 1'b1 || cfg_ready !== 1'b1 || busy !== 1'b0 || div_scale !== 8'd5) begin
            n_fail++;
            $display("FAIL manual_done: nrst=%b ready=%b busy=%b scale=%0d, want 1 1 0 5",
                     div_nrst, cfg_ready, busy, div_scale);
        end
    endtask

    task automatic test_same_scale_noop();
        send_req(8'd5);
        n_checks++;
        if (busy !== 1'b0 || div_nrst !== 1'b1 || div_scale !== 8'd5 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL noop_accept: busy=%b nrst=%b scale=%0d ready=%b, want 0 1 5 1",
                     busy, div_nrst, div_scale, cfg_ready);
        end
        repeat (20) tick();
        n_checks++;
        if (busy !== 1'b0 || div_nrst !== 1'b1 || div_scale !== 8'd5) begin
            n_fail++;
            $display("FAIL noop_later: busy=%b nrst=%b scale=%0d, want 0 1 5", busy, div_nrst, div_scale);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        div_stuck = 1'b1;
        repeat (3) tick();
        exp_q.push_back(8'd9);
        send_req(8'd9);
        wait_nrst_low(400, cyc);
        n_checks++;
        if (cyc != 255 || timeout_err !== 1'b1 || div_scale !== 8'd9) begin
            n_fail++;
            $display("FAIL timeout_apply: cycles=%0d terr=%b scale=%0d, want 255 1 9",
                     cyc, timeout_err, div_scale);
        end
        repeat (2) tick();
        div_stuck = 1'b0;
        exp_q.push_back(8'd3);
        send_req(8'd3);
        wait_nrst_low(100, cyc);
        n_checks++;
        if (cyc >= 100) begin
            n_fail++;
            $display("FAIL timeout_followup_wait: no update within %0d cycles", cyc);
        end
        repeat (2) tick();
        n_checks++;
        if (timeout_err !== 1'b1 || div_scale !== 8'd3 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_sticky: terr=%b scale=%0d busy=%b, want 1 3 0", timeout_err, div_scale, busy);
        end
    endtask

    task automatic test_sweep_wrap();
        logic [WIDTH-1:0] seq[5];
        int               cyc;
        seq = '{8'd2, 8'd3, 8'd4, 8'd2, 8'd3};
        apply_reset(2);
        sweep_lo = 8'd2;
        sweep_hi = 8'd4;
        dwell    = 8'd0;
        sweep_en = 1'b1;
        foreach (seq[k]) exp_q.push_back(seq[k]);
        for (int n = 0; n < 5; n++) begin
            cyc = 0;
            while (cyc < 60 && !(div_nrst === 1'b0 && prev_nrst === 1'b1)) begin
                tick();
                cyc++;
                n_checks++;
                if (cfg_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sweep_ready: cfg_ready=%b during sweep, want 0", cfg_ready);
                end
            end
            n_checks++;
            if (cyc >= 60 || div_scale !== seq[n]) begin
                n_fail++;
                $display("FAIL sweep_step%0d: scale=%0d after %0d cycles, want %0d", n, div_scale, cyc, seq[n]);
            end
            if (n == 4) sweep_en = 1'b0;
            tick();
        end
        repeat (2) tick();
        n_checks++;
        if (busy !== 1'b0 || div_scale !== 8'd3 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_exit: busy=%b scale=%0d ready=%b, want 0 3 1", busy, div_scale, cfg_ready);
        end
    endtask

    task automatic test_reset_mid_hold();
        int cyc;
        exp_q.push_back(8'd7);
        send_req(8'd7);
        wait_nrst_low(60, cyc);
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (div_scale !== 8'd1 || busy !== 1'b1 || div_nrst !== 1'b0 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midhold_reset: scale=%0d busy=%b nrst=%b ready=%b, want 1 1 0 0",
                     div_scale, busy, div_nrst, cfg_ready);
        end
        rst_n = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (div_scale !== 8'd1 || div_nrst !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midhold_release: scale=%0d nrst=%b busy=%b, want 1 1 0", div_scale, div_nrst, busy);
        end
        repeat (30) tick();
        n_checks++;
        if (div_scale !== 8'd1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midhold_discard: scale=%0d busy=%b, want 1 0", div_scale, busy);
        end
    endtask

    initial begin
        test_reset();
        test_manual_change();
        test_same_scale_noop();
        test_timeout();
        test_sweep_wrap();
        test_reset_mid_hold();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d expected updates never applied, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
